// File: rtl/down_counter_timer_pkg.sv
// ============================================================================
//  Module   : down_counter_timer_pkg
//  Purpose  : Shared definitions for the down-counter/timer and the sibling
//             register/counter blocks: controller state encoding and the
//             default datapath width.
//  Contents : state_t  - IDLE / RUN / DONE controller states
//             DCT_WIDTH - default counter/load width (7 bits)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package down_counter_timer_pkg;

  localparam int DCT_WIDTH = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : down_counter_timer_pkg

`default_nettype wire

// File: rtl/down_counter_timer_reg.sv
// ============================================================================
//  Module   : down_counter_timer_reg
//  Purpose  : WIDTH-bit enable register with asynchronous active-low clear.
//             Loads i_d on a rising clk edge when i_en is high, else holds.
//  Ports    : clk    - rising-edge clock
//             rst_n  - asynchronous active-low clear (output goes to 0)
//             i_en   - load enable
//             i_d    - next value
//             o_q    - registered value
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module down_counter_timer_reg
  import down_counter_timer_pkg::*;
#(
  parameter int WIDTH = DCT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule : down_counter_timer_reg

`default_nettype wire

// File: rtl/down_counter_timer.sv
// ============================================================================
//  Module   : down_counter_timer
//  Purpose  : Loadable down-counter/timer. Accepts a start value over a
//             valid/ready handshake, decrements once per enabled clock,
//             pulses done for one cycle on reaching zero and can optionally
//             reload the last accepted value and keep running.
//  Params   : WIDTH     - counter and load width in bits
//             RELOAD_EN - 1: auto-reload the last accepted value at zero
//  Ports    : clk        - rising-edge clock
//             reset_n    - asynchronous active-low reset
//             en         - count enable
//             load_valid - load request
//             load_data  - start value
//             load_ready - high in IDLE (load can be accepted)
//             abort      - cancel the current run
//             q          - current count (registered)
//             busy       - high in RUN
//             done       - one-cycle pulse in DONE
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module down_counter_timer
  import down_counter_timer_pkg::*;
#(
  parameter int WIDTH     = DCT_WIDTH,
  parameter int RELOAD_EN = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] c_ZERO = '0;
  localparam logic [WIDTH-1:0] c_ONE  = WIDTH'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_q_en;
  logic [WIDTH-1:0] w_q_d;
  logic             w_rl_en;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_reload;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath mux
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_q_en      = 1'b0;
    w_q_d       = w_q;
    w_rl_en     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (load_valid) begin
          w_q_en      = 1'b1;
          w_q_d       = load_data;
          w_rl_en     = 1'b1;
          // A zero load has nothing to count; report completion at once.
          w_state_nxt = (load_data != c_ZERO) ? ST_RUN : ST_DONE;
        end
      end

      ST_RUN: begin
        if (abort) begin
          w_q_en      = 1'b1;
          w_q_d       = c_ZERO;
          w_state_nxt = ST_IDLE;
        end else if (en) begin
          w_q_en = 1'b1;
          // Treat q<=1 as the terminal step so the count can never wrap.
          if (w_q <= c_ONE) begin
            w_q_d       = c_ZERO;
            w_state_nxt = ST_DONE;
          end else begin
            w_q_d = w_q - c_ONE;
          end
        end
      end

      ST_DONE: begin
        if ((RELOAD_EN != 0) && (w_reload != c_ZERO)) begin
          w_q_en      = 1'b1;
          w_q_d       = w_reload;
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_q_en      = 1'b1;
        w_q_d       = c_ZERO;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Count and reload registers
  // --------------------------------------------------------------------------
  down_counter_timer_reg #(
    .WIDTH (WIDTH)
  ) u_q_reg (
    .clk   (clk),
    .rst_n (reset_n),
    .i_en  (w_q_en),
    .i_d   (w_q_d),
    .o_q   (w_q)
  );

  down_counter_timer_reg #(
    .WIDTH (WIDTH)
  ) u_reload_reg (
    .clk   (clk),
    .rst_n (reset_n),
    .i_en  (w_rl_en),
    .i_d   (load_data),
    .o_q   (w_reload)
  );

  // --------------------------------------------------------------------------
  // Outputs: pure decodes of registered state
  // --------------------------------------------------------------------------
  assign q          = w_q;
  assign load_ready = (r_state == ST_IDLE);
  assign busy       = (r_state == ST_RUN);
  assign done       = (r_state == ST_DONE);

endmodule : down_counter_timer

`default_nettype wire

// File: tb/tb_down_counter_timer.sv
// ============================================================================
//  Module   : tb_down_counter_timer
//  Purpose  : Directed self-checking bench for down_counter_timer. Instance
//             dut has RELOAD_EN=0, instance dut_rl has RELOAD_EN=1.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_down_counter_timer;

  localparam int W = 7;

  logic         clk;
  logic         reset_n;

  logic         en, lv, ab;
  logic [W-1:0] ld;
  logic         rdy, busy, done;
  logic [W-1:0] q;

  logic         en2, lv2, ab2;
  logic [W-1:0] ld2;
  logic         rdy2, busy2, done2;
  logic [W-1:0] q2;

  int n_checks;
  int n_fail;

  down_counter_timer #(.WIDTH(W), .RELOAD_EN(0)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .load_valid (lv),
    .load_data  (ld),
    .load_ready (rdy),
    .abort      (ab),
    .q          (q),
    .busy       (busy),
    .done       (done)
  );

  down_counter_timer #(.WIDTH(W), .RELOAD_EN(1)) dut_rl (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en2),
    .load_valid (lv2),
    .load_data  (ld2),
    .load_ready (rdy2),
    .abort      (ab2),
    .q          (q2),
    .busy       (busy2),
    .done       (done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    en = 0; lv = 0; ab = 0; ld = '0;
    en2 = 0; lv2 = 0; ab2 = 0; ld2 = '0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    n_checks++; if (q !== 7'd0)  begin n_fail++; $display("FAIL reset_q got %0d want 0", q); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (rdy !== 1'b1)  begin n_fail++; $display("FAIL reset_ready got %b want 1", rdy); end
    n_checks++; if (q2 !== 7'd0 || rdy2 !== 1'b1) begin n_fail++; $display("FAIL reset_rl got q=%0d rdy=%b want q=0 rdy=1", q2, rdy2); end
  endtask

  task automatic test_reset_mid();
    en = 1; lv = 1; ld = 7'd10;
    tick();
    lv = 0;
    tick();
    tick();
    n_checks++; if (q !== 7'd8 || busy !== 1'b1) begin n_fail++; $display("FAIL mid_pre got q=%0d busy=%b want q=8 busy=1", q, busy); end
    #3 reset_n = 1'b0;
    #1;
    n_checks++; if (q !== 7'd0 || busy !== 1'b0 || rdy !== 1'b1) begin n_fail++; $display("FAIL mid_async got q=%0d busy=%b rdy=%b want 0 0 1", q, busy, rdy); end
    tick();
    n_checks++; if (q !== 7'd0 || done !== 1'b0) begin n_fail++; $display("FAIL mid_hold got q=%0d done=%b want 0 0", q, done); end
    reset_n = 1'b1;
    en = 0;
    tick();
    n_checks++; if (done !== 1'b0 || rdy !== 1'b1) begin n_fail++; $display("FAIL mid_after got done=%b rdy=%b want 0 1", done, rdy); end
  endtask

  task automatic test_basic();
    int npulse;
    npulse = 0;
    en = 1; lv = 1; ld = 7'd5;
    tick();
    lv = 0;
    n_checks++; if (q !== 7'd5 || busy !== 1'b1 || rdy !== 1'b0) begin n_fail++; $display("FAIL basic_load got q=%0d busy=%b rdy=%b want 5 1 0", q, busy, rdy); end
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (done) npulse++;
      n_checks++; if (q !== 7'(5 - k)) begin n_fail++; $display("FAIL basic_q step %0d got %0d want %0d", k, q, 5 - k); end
      n_checks++; if (done !== (k == 5)) begin n_fail++; $display("FAIL basic_done step %0d got %b want %b", k, done, (k == 5)); end
    end
    tick();
    if (done) npulse++;
    n_checks++; if (npulse != 1) begin n_fail++; $display("FAIL basic_pulses got %0d want 1", npulse); end
    n_checks++; if (rdy !== 1'b1 || q !== 7'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle got rdy=%b q=%0d busy=%b want 1 0 0", rdy, q, busy); end
  endtask

  task automatic test_enable_gating();
    logic       en_seq [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [6:0] q_exp  [5] = '{7'd2, 7'd2, 7'd1, 7'd1, 7'd0};
    en = 1; lv = 1; ld = 7'd3;
    tick();
    lv = 0;
    for (int k = 0; k < 5; k++) begin
      en = en_seq[k];
      // Load request while busy must be ignored.
      lv = (k == 1);
      ld = 7'd50;
      tick();
      n_checks++; if (q !== q_exp[k]) begin n_fail++; $display("FAIL gate_q step %0d got %0d want %0d", k, q, q_exp[k]); end
      n_checks++; if (done !== (k == 4)) begin n_fail++; $display("FAIL gate_done step %0d got %b want %b", k, done, (k == 4)); end
    end
    lv = 0;
    tick();
    n_checks++; if (rdy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL gate_end got rdy=%b done=%b want 1 0", rdy, done); end
  endtask

  task automatic test_abort();
    en = 1; lv = 1; ld = 7'd4;
    tick();
    lv = 0;
    tick();
    tick();
    n_checks++; if (q !== 7'd2) begin n_fail++; $display("FAIL abort_pre got %0d want 2", q); end
    ab = 1;
    tick();
    ab = 0;
    n_checks++; if (q !== 7'd0 || rdy !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL abort_mid got q=%0d rdy=%b busy=%b done=%b want 0 1 0 0", q, rdy, busy, done); end
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_nodone got %b want 0", done); end
    // Abort coinciding with the final decrement.
    lv = 1; ld = 7'd2;
    tick();
    lv = 0;
    tick();
    n_checks++; if (q !== 7'd1) begin n_fail++; $display("FAIL abort1_pre got %0d want 1", q); end
    ab = 1; en = 1;
    tick();
    ab = 0;
    n_checks++; if (q !== 7'd0 || done !== 1'b0 || rdy !== 1'b1) begin n_fail++; $display("FAIL abort1 got q=%0d done=%b rdy=%b want 0 0 1", q, done, rdy); end
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort1_nodone got %b want 0", done); end
  endtask

  task automatic test_edge_values();
    int busy_seen;
    en = 1; lv = 1; ld = 7'd0;
    tick();
    lv = 0;
    n_checks++; if (done !== 1'b1 || busy !== 1'b0 || q !== 7'd0) begin n_fail++; $display("FAIL zero_load got done=%b busy=%b q=%0d want 1 0 0", done, busy, q); end
    tick();
    n_checks++; if (done !== 1'b0 || busy !== 1'b0 || rdy !== 1'b1) begin n_fail++; $display("FAIL zero_after got done=%b busy=%b rdy=%b want 0 0 1", done, busy, rdy); end
    // Full scale.
    lv = 1; ld = 7'd127;
    tick();
    lv = 0;
    n_checks++; if (q !== 7'd127) begin n_fail++; $display("FAIL full_load got %0d want 127", q); end
    busy_seen = 0;
    for (int k = 1; k <= 127; k++) begin
      tick();
      if (busy) busy_seen++;
      if (k == 126) begin
        n_checks++; if (q !== 7'd1 || done !== 1'b0) begin n_fail++; $display("FAIL full_126 got q=%0d done=%b want 1 0", q, done); end
      end
      if (k == 64) begin
        n_checks++; if (q !== 7'd63) begin n_fail++; $display("FAIL full_64 got %0d want 63", q); end
      end
    end
    n_checks++; if (q !== 7'd0 || done !== 1'b1) begin n_fail++; $display("FAIL full_done got q=%0d done=%b want 0 1", q, done); end
    n_checks++; if (busy_seen != 126) begin n_fail++; $display("FAIL full_busy_cycles got %0d want 126", busy_seen); end
    tick();
    n_checks++; if (rdy !== 1'b1 || q !== 7'd0) begin n_fail++; $display("FAIL full_idle got rdy=%b q=%0d want 1 0", rdy, q); end
    en = 0;
  endtask

  task automatic test_reload();
    logic [6:0] q_exp [9] = '{7'd1, 7'd0, 7'd2, 7'd1, 7'd0, 7'd2, 7'd1, 7'd0, 7'd2};
    logic       d_exp [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    en2 = 1; lv2 = 1; ld2 = 7'd2;
    tick();
    lv2 = 0;
    n_checks++; if (q2 !== 7'd2 || busy2 !== 1'b1) begin n_fail++; $display("FAIL rl_load got q=%0d busy=%b want 2 1", q2, busy2); end
    for (int k = 0; k < 9; k++) begin
      tick();
      n_checks++; if (q2 !== q_exp[k] || done2 !== d_exp[k]) begin n_fail++; $display("FAIL rl_seq step %0d got q=%0d done=%b want q=%0d done=%b", k, q2, done2, q_exp[k], d_exp[k]); end
    end
    ab2 = 1;
    tick();
    ab2 = 0;
    n_checks++; if (q2 !== 7'd0 || rdy2 !== 1'b1 || done2 !== 1'b0) begin n_fail++; $display("FAIL rl_abort got q=%0d rdy=%b done=%b want 0 1 0", q2, rdy2, done2); end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++; if (done2 !== 1'b0 || busy2 !== 1'b0) begin n_fail++; $display("FAIL rl_stopped step %0d got done=%b busy=%b want 0 0", k, done2, busy2); end
    end
    en2 = 0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_reset_mid();
    test_basic();
    test_enable_gating();
    test_abort();
    test_edge_values();
    test_reload();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_down_counter_timer

`default_nettype wire
